// File: rtl/block_unpack_seq.sv
// block_unpack_seq
//   Accepts one 128-bit block over a valid/ready handshake. It then emits the
//   block as 4 x 32-bit words or 16 x 8-bit bytes over a second valid/ready
//   handshake. By default the most significant chunk goes out first.
//
// Parameters
//   LSB_FIRST     0: chunk 0 is bits [127:96] (word) or [127:120] (byte)
//                 1: chunk order is reversed
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous reset, active low
//   flush         synchronous abort: drop the held block and return to idle
//   in_valid      in_block / in_byte_mode are valid
//   in_ready      a block can be accepted this cycle
//   in_block      block to unpack
//   in_byte_mode  0: emit 4 words, 1: emit 16 bytes (latched at accept)
//   out_valid     out_data is valid
//   out_ready     consumer takes out_data this cycle
//   out_data      word, or byte in [7:0] with [31:8] = 0
//   out_idx       transfer-order index of the current chunk
//   out_last      the current chunk is the final one of the block
//   busy          a block is held
module block_unpack_seq #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_byte_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [3:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORD = 2'd1,
        BYTE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   count_q, count_d;
    logic [127:0] blk_q, blk_d;

    // Chunk position counted from the LSB end of the block.
    // For MSB-first order this is the bitwise complement of count.
    logic [1:0]   wpos;
    logic [3:0]   bpos;
    logic [31:0]  word_sel;
    logic [7:0]   byte_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        wpos     = LSB_FIRST ? count_q[1:0] : ~count_q[1:0];
        bpos     = LSB_FIRST ? count_q : ~count_q;
        word_sel = blk_q[{wpos, 5'b00000} +: 32];
        byte_sel = blk_q[{bpos, 3'b000} +: 8];

        busy      = (state_q != IDLE);
        out_valid = busy;
        in_ready  = (state_q == IDLE) && !flush;
        out_last  = ((state_q == WORD) && (count_q == 4'd3)) ||
                    ((state_q == BYTE) && (count_q == 4'd15));
        out_idx   = busy ? count_q : '0;
        out_data  = '0;
        if (state_q == WORD) begin
            out_data = word_sel;
        end else if (state_q == BYTE) begin
            out_data = {24'h000000, byte_sel};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        blk_d   = blk_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_d   = in_block;
                        count_d = '0;
                        state_d = in_byte_mode ? BYTE : WORD;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_d = IDLE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_unpack_seq.sv
module tb_block_unpack_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_block = '0;
    logic         in_byte_mode = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready0, out_valid0, out_last0, busy0;
    logic [31:0]  out_data0;
    logic [3:0]   out_idx0;
    logic         in_ready1, out_valid1, out_last1, busy1;
    logic [31:0]  out_data1;
    logic [3:0]   out_idx1;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    always #5 clk = ~clk;

    block_unpack_seq #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_block(in_block),
        .in_byte_mode(in_byte_mode), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0), .busy(busy0)
    );

    block_unpack_seq #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_block(in_block),
        .in_byte_mode(in_byte_mode), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the block is held as a byte array (byte 0 = MSB) and the
    // expected chunk is assembled from that array by transfer count.
    logic [127:0] m_blk = '0;
    bit           m_busy = 1'b0;
    bit           m_byte = 1'b0;
    int           m_n = 0;

    function automatic logic [31:0] exp_chunk(input logic [127:0] b, input bit bm,
                                              input int n, input bit lsb);
        logic [7:0] by [16];
        int k;
        for (int j = 0; j < 16; j++) by[j] = b[127 - 8*j -: 8];
        if (bm) begin
            k = lsb ? 15 - n : n;
            return {24'h0, by[k]};
        end
        k = lsb ? 3 - n : n;
        return {by[4*k], by[4*k+1], by[4*k+2], by[4*k+3]};
    endfunction

    initial begin
        bit         e_last;
        logic [31:0] e0, e1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_n    = 0;
                m_blk  = '0;
            end
            e_last = m_busy && (m_n == (m_byte ? 15 : 3));
            e0 = m_busy ? exp_chunk(m_blk, m_byte, m_n, 1'b0) : 32'h0;
            e1 = m_busy ? exp_chunk(m_blk, m_byte, m_n, 1'b1) : 32'h0;
            chk("m_valid0", {31'h0, out_valid0}, {31'h0, m_busy});
            chk("m_busy0",  {31'h0, busy0},      {31'h0, m_busy});
            chk("m_ready0", {31'h0, in_ready0},  {31'h0, !m_busy && !flush});
            chk("m_last0",  {31'h0, out_last0},  {31'h0, e_last});
            chk("m_idx0",   {28'h0, out_idx0},   m_busy ? 32'(m_n) : 32'h0);
            chk("m_data0",  out_data0, e0);
            chk("m_valid1", {31'h0, out_valid1}, {31'h0, m_busy});
            chk("m_idx1",   {28'h0, out_idx1},   m_busy ? 32'(m_n) : 32'h0);
            chk("m_last1",  {31'h0, out_last1},  {31'h0, e_last});
            chk("m_data1",  out_data1, e1);
            if (rst_n) begin
                if (flush) begin
                    m_busy = 1'b0;
                    m_n    = 0;
                end else if (m_busy) begin
                    if (out_ready) begin
                        if (e_last) begin
                            m_busy = 1'b0;
                            m_n    = 0;
                        end else begin
                            m_n++;
                        end
                    end
                end else if (in_valid) begin
                    m_busy = 1'b1;
                    m_byte = in_byte_mode;
                    m_blk  = in_block;
                    m_n    = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] b, input bit bm);
        in_valid     = 1'b1;
        in_block     = b;
        in_byte_mode = bm;
        step();
        in_valid     = 1'b0;
        in_block     = '0;
    endtask

    logic [31:0] words_a [4];

    initial begin
        words_a = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", {31'h0, in_ready0}, 32'h1);
        chk("rst_valid", {31'h0, out_valid0}, 32'h0);
        chk("rst_data",  out_data0, 32'h0);

        // Word mode, both chunk orders
        out_ready = 1'b1;
        accept(BLK_A, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("word_data",  out_data0, words_a[i]);
            chk("word_idx",   {28'h0, out_idx0}, 32'(i));
            chk("word_last",  {31'h0, out_last0}, (i == 3) ? 32'h1 : 32'h0);
            chk("lsbf_data",  out_data1, words_a[3 - i]);
            step();
        end
        chk("word_ready_after", {31'h0, in_ready0}, 32'h1);

        // Byte mode
        accept(BLK_A, 1'b1);
        for (int j = 0; j < 16; j++) begin
            chk("byte_data", out_data0, 32'(j * 17));
            chk("byte_last", {31'h0, out_last0}, (j == 15) ? 32'h1 : 32'h0);
            step();
        end
        chk("byte_ready_after", {31'h0, in_ready0}, 32'h1);

        // Backpressure at word index 2
        accept(BLK_A, 1'b0);
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", out_data0, 32'h8899AABB);
            chk("bp_idx",  {28'h0, out_idx0}, 32'h2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_resume_data", out_data0, 32'hCCDDEEFF);
        chk("bp_resume_idx",  {28'h0, out_idx0}, 32'h3);
        step();

        // Flush at byte index 5
        accept(BLK_A, 1'b1);
        repeat (5) step();
        chk("fl_idx",  {28'h0, out_idx0}, 32'h5);
        chk("fl_data", out_data0, 32'h55);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'h0, in_ready0}, 32'h0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_valid", {31'h0, out_valid0}, 32'h0);
        chk("fl_busy",  {31'h0, busy0}, 32'h0);
        chk("fl_ready", {31'h0, in_ready0}, 32'h1);
        accept(BLK_B, 1'b0);
        chk("fl_next_idx",  {28'h0, out_idx0}, 32'h0);
        chk("fl_next_data", out_data0, 32'hDEADBEEF);
        chk("fl_next_lsbf", out_data1, 32'hCAFEF00D);
        repeat (4) step();

        // Reset mid-byte at count 7
        accept(BLK_A, 1'b1);
        repeat (7) step();
        chk("rb_idx", {28'h0, out_idx0}, 32'h7);
        rst_n = 1'b0;
        #1;
        chk("rb_valid", {31'h0, out_valid0}, 32'h0);
        chk("rb_busy",  {31'h0, busy0}, 32'h0);
        chk("rb_data",  out_data0, 32'h0);
        chk("rb_idx0",  {28'h0, out_idx0}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rb_ready", {31'h0, in_ready0}, 32'h1);
        accept(BLK_A, 1'b0);
        chk("rb_restart", out_data0, 32'h00112233);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
